// File: rtl/axis_gate_sequencer_pkg.sv
// Shared definitions for the gate descriptor sequencer: FSM encoding and
// the bit layout of a 128-bit gate descriptor.
package axis_gate_sequencer_pkg;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] ADDR = 3'd1;
    localparam logic [2:0] WAIT = 3'd2;
    localparam logic [2:0] SEND = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    localparam int FIELD_WIDTH = 32;
    localparam int ON_LSB      = 0;
    localparam int OFF_LSB     = 32;
    localparam int END_LSB     = 64;
    localparam int POFF_LSB    = 96;

    function automatic logic [127:0] make_desc(
        input logic [FIELD_WIDTH-1:0] on_cnt,
        input logic [FIELD_WIDTH-1:0] off_cnt,
        input logic [FIELD_WIDTH-1:0] period_end,
        input logic [FIELD_WIDTH-1:0] phase_off
    );
        logic [127:0] d;
        d = '0;
        d[ON_LSB   +: FIELD_WIDTH] = on_cnt;
        d[OFF_LSB  +: FIELD_WIDTH] = off_cnt;
        d[END_LSB  +: FIELD_WIDTH] = period_end;
        d[POFF_LSB +: FIELD_WIDTH] = phase_off;
        return d;
    endfunction

endpackage

// File: rtl/axis_gate_sequencer.sv
// Walks a BRAM table of gate descriptors (entries 0..cfg_last) and streams one
// descriptor per AXI4-Stream transfer, for cfg_loops passes (0 = endless).
module axis_gate_sequencer #(
    parameter int BRAM_ADDR_WIDTH = 10,
    parameter int BRAM_DATA_WIDTH = 128,
    parameter int CNTR_WIDTH      = 32
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       cfg_enbl,
    input  logic [BRAM_ADDR_WIDTH-1:0] cfg_last,
    input  logic [CNTR_WIDTH-1:0]      cfg_loops,
    output logic                       bram_porta_clk,
    output logic                       bram_porta_rst,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_porta_addr,
    input  logic [BRAM_DATA_WIDTH-1:0] bram_porta_rddata,
    input  logic                       m_axis_tready,
    output logic [BRAM_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                       m_axis_tvalid,
    output logic                       sts_busy,
    output logic                       sts_done,
    output logic [CNTR_WIDTH-1:0]      sts_loop
);
    import axis_gate_sequencer_pkg::*;

    logic [2:0]                 state_reg, state_next;
    logic [BRAM_ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [BRAM_DATA_WIDTH-1:0] tdata_reg, tdata_next;
    logic                       tvalid_reg, tvalid_next;
    logic [CNTR_WIDTH-1:0]      loop_reg, loop_next;
    logic [CNTR_WIDTH-1:0]      loop_inc;
    logic                       final_pass;

    assign loop_inc   = loop_reg + CNTR_WIDTH'(1);
    assign final_pass = (cfg_loops != '0) && (loop_inc == cfg_loops);

    always_comb begin
        state_next  = state_reg;
        addr_next   = addr_reg;
        tdata_next  = tdata_reg;
        tvalid_next = tvalid_reg;
        loop_next   = loop_reg;
        case (state_reg)
            IDLE: begin
                if (cfg_enbl) begin
                    addr_next  = '0;
                    loop_next  = '0;
                    state_next = ADDR;
                end
            end
            ADDR: state_next = cfg_enbl ? WAIT : IDLE;
            WAIT: begin
                if (cfg_enbl) begin
                    tdata_next  = bram_porta_rddata;
                    tvalid_next = 1'b1;
                    state_next  = SEND;
                end else begin
                    state_next = IDLE;
                end
            end
            SEND: begin
                // A presented word is always delivered, even after cfg_enbl drops.
                if (m_axis_tready) begin
                    tvalid_next = 1'b0;
                    if (!cfg_enbl) begin
                        state_next = IDLE;
                    end else if (addr_reg != cfg_last) begin
                        addr_next  = addr_reg + BRAM_ADDR_WIDTH'(1);
                        state_next = ADDR;
                    end else begin
                        addr_next  = '0;
                        loop_next  = loop_inc;
                        state_next = final_pass ? DONE : ADDR;
                    end
                end
            end
            DONE: begin
                if (!cfg_enbl) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_reg  <= IDLE;
            addr_reg   <= '0;
            tdata_reg  <= '0;
            tvalid_reg <= 1'b0;
            loop_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            addr_reg   <= addr_next;
            tdata_reg  <= tdata_next;
            tvalid_reg <= tvalid_next;
            loop_reg   <= loop_next;
        end
    end

    assign bram_porta_clk  = aclk;
    assign bram_porta_rst  = ~aresetn;
    assign bram_porta_addr = addr_reg;
    assign m_axis_tdata    = tdata_reg;
    assign m_axis_tvalid   = tvalid_reg;
    assign sts_busy        = (state_reg == ADDR) || (state_reg == WAIT) || (state_reg == SEND);
    assign sts_done        = (state_reg == DONE);
    assign sts_loop        = loop_reg;

endmodule

// File: tb/tb_axis_gate_sequencer.sv
// Directed bench for axis_gate_sequencer with a table-walk scoreboard that
// predicts each delivered descriptor and the completed-pass count.
module tb_axis_gate_sequencer;
    import axis_gate_sequencer_pkg::*;

    localparam int AW = 10;
    localparam int DW = 128;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic          cfg_enbl = 1'b0;
    logic [AW-1:0] cfg_last = '0;
    logic [CW-1:0] cfg_loops = '0;
    logic          bram_clk, bram_rst;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_rddata = '0;
    logic          tready = 1'b0;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          sts_busy, sts_done;
    logic [CW-1:0] sts_loop;

    logic [DW-1:0] bram [0:(1<<AW)-1];

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    // scoreboard state for the current run
    int            pos = 0;
    int            hs_run = 0;
    logic [CW-1:0] loops_m = '0;
    int            hs_edges[$];
    logic [DW-1:0] got[$];
    int            start_edge = 0;

    logic [DW-1:0] desc_a, desc_b, desc_c;

    always #5 clk = ~clk;

    axis_gate_sequencer #(
        .BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW), .CNTR_WIDTH(CW)
    ) dut (
        .aclk(clk), .aresetn(aresetn),
        .cfg_enbl(cfg_enbl), .cfg_last(cfg_last), .cfg_loops(cfg_loops),
        .bram_porta_clk(bram_clk), .bram_porta_rst(bram_rst),
        .bram_porta_addr(bram_addr), .bram_porta_rddata(bram_rddata),
        .m_axis_tready(tready), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
        .sts_busy(sts_busy), .sts_done(sts_done), .sts_loop(sts_loop)
    );

    always @(posedge clk) begin
        bram_rddata <= bram[bram_addr];
        cyc <= cyc + 1;
    end

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Compare process: sampled on the falling edge, inputs only change just after rising edges.
    logic          prev_valid = 1'b0, prev_hs = 1'b0, prev_rst = 1'b1;
    logic [DW-1:0] prev_data = '0;
    always @(negedge clk) begin
        if (aresetn && !prev_rst) begin
            check("sts_loop_model", sts_loop, DW'(loops_m));
            if (prev_valid && !prev_hs) begin
                check("tvalid_hold", tvalid, 1);
                check("tdata_hold", tdata, prev_data);
            end
            if (tvalid && tready) begin
                check("tdata_model", tdata, bram[pos]);
                $display("xfer %0d: edge %0d entry %0d tdata %0h", hs_run, cyc + 1, pos, tdata);
                got.push_back(tdata);
                hs_edges.push_back(cyc + 1);
                hs_run++;
                if (pos == int'(cfg_last)) begin
                    pos = 0;
                    loops_m = loops_m + 1;
                end else begin
                    pos++;
                end
            end
        end
        prev_rst   = !aresetn;
        prev_valid = tvalid;
        prev_hs    = tvalid && tready;
        prev_data  = tdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        cfg_enbl = 1'b1;
        @(posedge clk);
        #1;
        start_edge = cyc;
        pos = 0;
        hs_run = 0;
        loops_m = '0;
        hs_edges.delete();
        got.delete();
    endtask

    task automatic wait_hs(input int n, input int budget, input string nm);
        int k = 0;
        while (hs_run < n && k < budget) begin tick(); k++; end
        check(nm, DW'(hs_run >= n), 1);
    endtask

    task automatic wait_valid(input int budget, input string nm);
        int k = 0;
        while (!tvalid && k < budget) begin tick(); k++; end
        check(nm, tvalid, 1);
    endtask

    task automatic wait_done(input int budget, input string nm);
        int k = 0;
        while (!sts_done && k < budget) begin tick(); k++; end
        check(nm, sts_done, 1);
    endtask

    initial begin
        logic [DW-1:0] held_data;
        logic [AW-1:0] held_addr;
        int            hs_before;

        desc_a = make_desc(32'h0000_0010, 32'h0000_0020, 32'h0000_0100, 32'h0000_0001);
        desc_b = make_desc(32'h0000_0030, 32'h0000_0040, 32'h0000_0200, 32'h0000_0002);
        desc_c = make_desc(32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1234_5678, 32'h8765_4321);
        for (int i = 0; i < (1 << AW); i++) bram[i] = '0;
        bram[0] = desc_a;
        bram[1] = desc_b;
        bram[2] = desc_c;

        // reset state
        repeat (3) tick();
        check("rst_bram_rst", bram_rst, 1);
        check("rst_tvalid", tvalid, 0);
        check("rst_tdata", tdata, 0);
        check("rst_addr", bram_addr, 0);
        check("rst_busy", sts_busy, 0);
        check("rst_done", sts_done, 0);
        check("rst_loop", sts_loop, 0);
        aresetn = 1'b1;
        tick();
        check("run_bram_rst", bram_rst, 0);
        check("idle_tvalid", tvalid, 0);

        // basic sequence A,B,C, one pass
        cfg_last = 10'd2; cfg_loops = 32'd1; tready = 1'b1;
        start_run();
        check("basic_busy", sts_busy, 1);
        wait_done(30, "basic_reach_done");
        check("basic_hs_count", hs_run, 3);
        if (got.size() == 3) begin
            check("basic_word0", got[0], desc_a);
            check("basic_word1", got[1], desc_b);
            check("basic_word2", got[2], desc_c);
            check("basic_lat0", hs_edges[0] - start_edge, 3);
            check("basic_lat1", hs_edges[1] - hs_edges[0], 3);
            check("basic_lat2", hs_edges[2] - hs_edges[1], 3);
        end
        check("basic_loop", sts_loop, 1);
        repeat (4) begin
            tick();
            check("basic_no_more_valid", tvalid, 0);
        end
        check("basic_hs_final", hs_run, 3);
        cfg_enbl = 1'b0;
        tick();
        check("basic_done_clear", sts_done, 0);

        // backpressure
        cfg_last = 10'd2; cfg_loops = 32'd0; tready = 1'b0;
        start_run();
        wait_valid(10, "bp_valid");
        held_data = tdata;
        held_addr = bram_addr;
        check("bp_first_word", held_data, desc_a);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid_stable", tvalid, 1);
            check("bp_data_stable", tdata, held_data);
            check("bp_addr_stable", bram_addr, held_addr);
        end
        tready = 1'b1;
        tick();
        check("bp_hs_once", hs_run, 1);
        check("bp_valid_drop", tvalid, 0);
        check("bp_addr_adv", bram_addr, 1);
        tready = 1'b0;
        cfg_enbl = 1'b0;
        tick();
        check("bp_abort_busy", sts_busy, 0);

        // endless single entry
        cfg_last = 10'd0; cfg_loops = 32'd0; tready = 1'b1;
        start_run();
        for (int k = 0; k < 40 && hs_run < 5; k++) begin
            tick();
            check("endless_no_done", sts_done, 0);
        end
        check("endless_hs5", hs_run, 5);
        cfg_enbl = 1'b0;
        check("endless_loop5", sts_loop, 5);
        tick();
        check("endless_idle", sts_busy, 0);
        check("endless_loop_hold", sts_loop, 5);

        // abort during SEND
        cfg_last = 10'd2; cfg_loops = 32'd0; tready = 1'b0;
        start_run();
        wait_valid(10, "abort_valid");
        cfg_enbl = 1'b0;
        repeat (3) begin
            tick();
            check("abort_hold_valid", tvalid, 1);
        end
        tready = 1'b1;
        tick();
        check("abort_hs_once", hs_run, 1);
        check("abort_valid_low", tvalid, 0);
        check("abort_busy_low", sts_busy, 0);
        repeat (5) begin
            tick();
            check("abort_stay_idle", tvalid, 0);
        end
        check("abort_no_redeliver", hs_run, 1);

        // restart from DONE
        cfg_last = 10'd1; cfg_loops = 32'd2; tready = 1'b1;
        start_run();
        wait_done(40, "restart_reach_done");
        check("restart_hs4", hs_run, 4);
        check("restart_loop2", sts_loop, 2);
        repeat (5) begin
            tick();
            check("restart_hold_done", sts_done, 1);
            check("restart_hold_valid", tvalid, 0);
        end
        cfg_enbl = 1'b0;
        tick();
        check("restart_exit_done", sts_done, 0);
        check("restart_exit_busy", sts_busy, 0);
        check("restart_loop_kept", sts_loop, 2);
        start_run();
        check("restart_addr0", bram_addr, 0);
        check("restart_loop0", sts_loop, 0);
        check("restart_busy", sts_busy, 1);
        wait_hs(1, 10, "restart_first_hs");
        if (got.size() >= 1) check("restart_word0", got[0], desc_a);
        cfg_enbl = 1'b0;
        repeat (2) tick();

        // reset mid-WAIT
        cfg_last = 10'd2; cfg_loops = 32'd0; tready = 1'b1;
        start_run();
        tick();
        aresetn = 1'b0;
        cfg_enbl = 1'b0;
        tick();
        check("mrst_tvalid", tvalid, 0);
        check("mrst_tdata", tdata, 0);
        check("mrst_addr", bram_addr, 0);
        check("mrst_busy", sts_busy, 0);
        check("mrst_done", sts_done, 0);
        check("mrst_loop", sts_loop, 0);
        aresetn = 1'b1;
        repeat (5) begin
            tick();
            check("mrst_no_valid", tvalid, 0);
        end
        start_run();
        wait_hs(1, 10, "mrst_rerun_hs");
        if (got.size() >= 1) check("mrst_rerun_word0", got[0], desc_a);
        cfg_enbl = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/axis_gate_sequencer.md
Name: axis_gate_sequencer

Overview:
- Upstream feeder for the gate controller.
- Walks a table of 128-bit gate descriptors held in BRAM (fields: [31:0] gate-on count, [63:32] gate-off count, [95:64] period end, [127:96] phase offset) and emits one descriptor per AXI4-Stream transfer.
- Supports a programmable table length and loop count (finite or endless), and reports progress for software polling.

Parameters:
- BRAM_ADDR_WIDTH, 10, BRAM address width; table depth up to 2**BRAM_ADDR_WIDTH entries.
- BRAM_DATA_WIDTH, 128, BRAM word width, equal to the m_axis_tdata width.
- CNTR_WIDTH, 32, loop-count and status counter width.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset. One clock; reset is synchronous and active-low.
- cfg_enbl  in  1  run enable, level-sensitive.
- cfg_last  in  BRAM_ADDR_WIDTH  index of the last table entry; the table spans 0..cfg_last.
- cfg_loops  in  CNTR_WIDTH  number of table passes; 0 = endless.
- bram_porta_clk  out  1  equal to aclk.
- bram_porta_rst  out  1  equal to ~aresetn.
- bram_porta_addr  out  BRAM_ADDR_WIDTH  registered read address.
- bram_porta_rddata  in  BRAM_DATA_WIDTH  read data; valid one clock after the address is sampled.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  BRAM_DATA_WIDTH  descriptor.
- m_axis_tvalid  out  1  descriptor valid.
- sts_busy  out  1  high in ADDR, WAIT and SEND.
- sts_done  out  1  high in DONE.
- sts_loop  out  CNTR_WIDTH  completed passes.

Behaviour:
- Reset values: addr=0, tdata=0, tvalid=0, sts_busy=0, sts_done=0, sts_loop=0, state=IDLE.
- States: IDLE, ADDR, WAIT, SEND, DONE.
- IDLE:
  - cfg_enbl=1 -> addr=0, sts_loop=0, go to ADDR.
  - cfg_enbl=0 -> stay in IDLE.
- ADDR: BRAM samples addr on this edge -> WAIT.
- WAIT: capture bram_porta_rddata into tdata, set tvalid=1 -> SEND.
- SEND: hold tdata/tvalid stable until tready=1. On the handshake edge, tvalid=0, then:
  - cfg_enbl=0 -> IDLE; sts_loop holds its value.
  - addr != cfg_last -> addr+1, go to ADDR.
  - addr == cfg_last -> addr=0, sts_loop+1. Then:
    - cfg_loops != 0 and sts_loop+1 == cfg_loops -> DONE.
    - otherwise -> ADDR.
- DONE: sts_done=1, tvalid=0. Leave to IDLE only when cfg_enbl=0; sts_done clears on that exit.
- Latency:
  - First tvalid rises 3 clocks after the IDLE edge that sees cfg_enbl=1.
  - Each later descriptor rises 3 clocks after the previous handshake.
  - Peak throughput is one word per 3 clocks, which is sufficient because the consumer accepts at most one word per gate period.
- AXIS rule: once tvalid is high, tdata and tvalid must not change until the handshake, even if cfg_enbl drops.
- Abort:
  - cfg_enbl=0 in ADDR or WAIT -> IDLE on the next edge with tvalid=0.
  - cfg_enbl=0 in SEND -> finish the pending handshake, then IDLE.
- cfg_last and cfg_loops are sampled live; software must change them only in IDLE or DONE.
- cfg_last=0: single-entry table; every handshake completes a pass.
- cfg_loops=0: sts_loop wraps modulo 2**CNTR_WIDTH; never enters DONE.
- Address wrap is explicit at cfg_last, never by natural overflow. If cfg_last = 2**BRAM_ADDR_WIDTH-1, the wrap coincides with overflow and must give the same result.
- Reset mid-run returns every register to its reset value on the next edge, including a pending tvalid.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE=0, ADDR=1, WAIT=2, SEND=3, DONE=4, 3 bits);
  - descriptor field offsets (ON_LSB=0, OFF_LSB=32, END_LSB=64, POFF_LSB=96, FIELD_WIDTH=32).
- Single flat module, no sub-module; the output register stage is too small to warrant splitting out.

Test Plan:
- Basic sequence: cfg_last=2, cfg_loops=1, BRAM[0..2]=A,B,C, tready=1.
  - Response: tdata A,B,C, each tvalid rising 3 clocks after the previous handshake.
  - Then sts_done=1, sts_loop=1, no further tvalid.
- Backpressure: tready=0 for 10 clocks while tvalid=1.
  - Response: tdata/tvalid stable for all 10 clocks; addr does not advance; handshake occurs on the first tready=1 edge.
- Endless looping: cfg_last=0, cfg_loops=0, run 5 handshakes.
  - Response: tdata=BRAM[0] each time; sts_loop=5; sts_done stays 0.
- Abort during SEND: drop cfg_enbl while tvalid=1 and tready=0, then raise tready.
  - Response: word delivered once; IDLE next; tvalid=0; sts_busy=0.
- Restart from DONE: reach DONE, hold cfg_enbl=1 for 5 clocks, drop it, then raise it again.
  - Response: stays in DONE while high; IDLE on the drop; new run starts at addr=0 with sts_loop=0.
- Reset mid-WAIT: assert aresetn=0 for one clock.
  - Response: all outputs at reset values next cycle; no tvalid until cfg_enbl is reapplied.
